// File: rtl/video_timing_checker.sv
// video_timing_checker: measures line/frame geometry of a parallel video stream,
// compares it against expected parameters, tracks lock and counts timing errors.
// Optional colour-bar pixel check is built when PATTERN_CHECK_EN is defined.
module video_timing_checker #(
    parameter logic [15:0] H_TOTAL     = 16'd1252,
    parameter logic [15:0] H_VAL       = 16'd1242,
    parameter logic [15:0] V_TOTAL     = 16'd2707,
    parameter logic [15:0] V_VAL       = 16'd1920,
    parameter logic [3:0]  LOCK_FRAMES = 4'd2,
    parameter logic [15:0] BAR_W       = 16'd90
) (
    input  logic        px_clk,
    input  logic        rstn,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        dval,
    input  logic [23:0] px_data,
    output logic [15:0] meas_h_total,
    output logic [15:0] meas_h_val,
    output logic [15:0] meas_v_total,
    output logic [15:0] meas_v_val,
    output logic [15:0] frame_cnt,
    output logic        locked,
    output logic        timing_err,
    output logic [7:0]  err_cnt,
    output logic [15:0] pix_err_cnt
);

    localparam int unsigned CW  = 16;
    localparam logic [CW-1:0] SAT    = 16'hFFFF;
    localparam logic [CW-1:0] TO_HIT = 16'hFFFE;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    logic           r_hs1, r_vs1, r_dv1;
    logic           r_hs2, r_vs2, r_dv2;
    logic           w_hs_rise, w_vs_rise, w_dv_fall, w_first_dv;
    logic [CW-1:0]  r_line_cnt, r_line_len;
    logic [CW-1:0]  r_act_cnt, r_act_len;
    logic           r_line_dv;
    logic [CW-1:0]  r_v_tot, r_v_act;
    logic [CW-1:0]  r_to_cnt;
    logic           w_timeout, w_match, w_frame_end, w_mismatch;
    state_t         r_state, w_state_nxt;
    logic [3:0]     r_match_cnt, w_match_nxt, w_match_inc;
    logic           r_locked, r_terr;
    logic [CW-1:0]  r_meas_h_total, r_meas_h_val, r_meas_v_total, r_meas_v_val;
    logic [CW-1:0]  r_frame_cnt;
    logic [7:0]     r_err_cnt;

    // Input stage S1 plus one-cycle history for edge detection
    always_ff @(posedge px_clk or negedge rstn) begin
        if (!rstn) begin
            r_hs1 <= 1'b0; r_vs1 <= 1'b0; r_dv1 <= 1'b0;
            r_hs2 <= 1'b0; r_vs2 <= 1'b0; r_dv2 <= 1'b0;
        end else begin
            r_hs1 <= hsync; r_vs1 <= vsync; r_dv1 <= dval;
            r_hs2 <= r_hs1; r_vs2 <= r_vs1; r_dv2 <= r_dv1;
        end
    end

    assign w_hs_rise  = r_hs1 & ~r_hs2;
    assign w_vs_rise  = r_vs1 & ~r_vs2;
    assign w_dv_fall  = ~r_dv1 & r_dv2;
    assign w_first_dv = r_dv1 & (w_hs_rise | ~r_line_dv);

    // Line length: cycles from one hsync rise to the next
    always_ff @(posedge px_clk or negedge rstn) begin
        if (!rstn) begin
            r_line_cnt <= '0;
            r_line_len <= '0;
        end else if (w_hs_rise) begin
            r_line_cnt <= 16'd1;
            r_line_len <= r_line_cnt;
        end else if (r_line_cnt != SAT) begin
            r_line_cnt <= r_line_cnt + 16'd1;
        end
    end

    // Active length per line, latched on the dval fall; per-line dval flag
    always_ff @(posedge px_clk or negedge rstn) begin
        if (!rstn) begin
            r_act_cnt <= '0;
            r_act_len <= '0;
            r_line_dv <= 1'b0;
        end else begin
            if (w_hs_rise)
                r_act_cnt <= {15'd0, r_dv1};
            else if (r_dv1 && (r_act_cnt != SAT))
                r_act_cnt <= r_act_cnt + 16'd1;
            if (w_dv_fall)
                r_act_len <= r_act_cnt;
            r_line_dv <= w_hs_rise ? r_dv1 : (r_line_dv | r_dv1);
        end
    end

    // Frame counters; a line starting with the vsync rise belongs to the new frame
    always_ff @(posedge px_clk or negedge rstn) begin
        if (!rstn) begin
            r_v_tot <= '0;
            r_v_act <= '0;
        end else if (w_vs_rise) begin
            r_v_tot <= {15'd0, w_hs_rise};
            r_v_act <= {15'd0, w_first_dv};
        end else begin
            if (w_hs_rise && (r_v_tot != SAT))
                r_v_tot <= r_v_tot + 16'd1;
            if (w_first_dv && (r_v_act != SAT))
                r_v_act <= r_v_act + 16'd1;
        end
    end

    // Cycles since the last hsync rise; fires once when the gap reaches 65535
    always_ff @(posedge px_clk or negedge rstn) begin
        if (!rstn)
            r_to_cnt <= '0;
        else if (w_hs_rise)
            r_to_cnt <= '0;
        else if (r_to_cnt != SAT)
            r_to_cnt <= r_to_cnt + 16'd1;
    end

    assign w_timeout   = ~w_hs_rise & (r_to_cnt == TO_HIT);
    assign w_match     = (r_line_len == H_TOTAL) && (r_act_len == H_VAL) &&
                         (r_v_tot == V_TOTAL) && (r_v_act == V_VAL);
    assign w_frame_end = w_vs_rise & ~w_timeout & (r_state != ST_IDLE);
    assign w_mismatch  = w_frame_end & ~w_match;
    assign w_match_inc = r_match_cnt + 4'd1;

    // Lock FSM state register
    always_ff @(posedge px_clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_match_cnt <= '0;
            r_locked    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_match_cnt <= w_match_nxt;
            r_locked    <= (w_state_nxt == ST_LOCKED);
        end
    end

    // Lock FSM next state
    always_comb begin
        w_state_nxt = r_state;
        w_match_nxt = r_match_cnt;
        if (w_timeout) begin
            w_state_nxt = ST_IDLE;
            w_match_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_vs_rise) begin
                        w_state_nxt = ST_MEASURE;
                        w_match_nxt = '0;
                    end
                end
                ST_MEASURE: begin
                    if (w_frame_end) begin
                        if (!w_match) begin
                            w_match_nxt = '0;
                        end else if (w_match_inc >= LOCK_FRAMES) begin
                            w_state_nxt = ST_LOCKED;
                            w_match_nxt = '0;
                        end else begin
                            w_match_nxt = w_match_inc;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_mismatch) begin
                        w_state_nxt = ST_MEASURE;
                        w_match_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_match_nxt = '0;
                end
            endcase
        end
    end

    // Per-frame results: measurements, frame count, error pulse and count
    always_ff @(posedge px_clk or negedge rstn) begin
        if (!rstn) begin
            r_meas_h_total <= '0;
            r_meas_h_val   <= '0;
            r_meas_v_total <= '0;
            r_meas_v_val   <= '0;
            r_frame_cnt    <= '0;
            r_terr         <= 1'b0;
            r_err_cnt      <= '0;
        end else begin
            r_terr <= w_mismatch;
            if (w_frame_end) begin
                r_meas_h_total <= r_line_len;
                r_meas_h_val   <= r_act_len;
                r_meas_v_total <= r_v_tot;
                r_meas_v_val   <= r_v_act;
                r_frame_cnt    <= r_frame_cnt + 16'd1;
            end
            if (w_mismatch && (r_err_cnt != 8'hFF))
                r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

`ifdef PATTERN_CHECK_EN
    logic [23:0]   r_px1;
    logic [CW-1:0] r_bar_pos;
    logic [2:0]    r_bar_idx;
    logic [23:0]   w_exp_px;
    logic [CW-1:0] r_pix_err_cnt;

    // Expected colour for the current bar
    always_comb begin
        w_exp_px = 24'hFF0000;
        case (r_bar_idx)
            3'd0: w_exp_px = 24'hFF0000;
            3'd1: w_exp_px = 24'h00FF00;
            3'd2: w_exp_px = 24'h0000FF;
            3'd3: w_exp_px = 24'hFFFFFF;
            3'd4: w_exp_px = 24'hFFFF00;
            3'd5: w_exp_px = 24'h00FFFF;
            3'd6: w_exp_px = 24'hFF00FF;
            3'd7: w_exp_px = 24'h123456;
        endcase
    end

    // Bar position tracking within a dval run and pixel mismatch count
    always_ff @(posedge px_clk or negedge rstn) begin
        if (!rstn) begin
            r_px1         <= '0;
            r_bar_pos     <= '0;
            r_bar_idx     <= '0;
            r_pix_err_cnt <= '0;
        end else begin
            r_px1 <= px_data;
            if (!r_dv1) begin
                r_bar_pos <= '0;
                r_bar_idx <= '0;
            end else if (r_bar_pos == (BAR_W - 16'd1)) begin
                r_bar_pos <= '0;
                if (r_bar_idx != 3'd7)
                    r_bar_idx <= r_bar_idx + 3'd1;
            end else begin
                r_bar_pos <= r_bar_pos + 16'd1;
            end
            if (r_dv1 && (r_px1 != w_exp_px) && (r_pix_err_cnt != SAT))
                r_pix_err_cnt <= r_pix_err_cnt + 16'd1;
        end
    end

    assign pix_err_cnt = r_pix_err_cnt;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{px_data, BAR_W};
    assign pix_err_cnt  = '0;
`endif

    assign meas_h_total = r_meas_h_total;
    assign meas_h_val   = r_meas_h_val;
    assign meas_v_total = r_meas_v_total;
    assign meas_v_val   = r_meas_v_val;
    assign frame_cnt    = r_frame_cnt;
    assign locked       = r_locked;
    assign timing_err   = r_terr;
    assign err_cnt      = r_err_cnt;

endmodule

// File: tb/tb_video_timing_checker.sv
// Scoreboard bench for video_timing_checker using a reduced geometry
// (110 x 8 lines, 100 active px, 5 active lines, 12-px bars).
module tb_video_timing_checker;

    logic        px_clk = 1'b0;
    logic        rstn   = 1'b0;
    logic        hsync  = 1'b0;
    logic        vsync  = 1'b0;
    logic        dval   = 1'b0;
    logic [23:0] px_data = 24'd0;
    logic [15:0] meas_h_total, meas_h_val, meas_v_total, meas_v_val;
    logic [15:0] frame_cnt, pix_err_cnt;
    logic        locked, timing_err;
    logic [7:0]  err_cnt;

`ifdef PATTERN_CHECK_EN
    localparam logic [15:0] PIX1 = 16'd1;
`else
    localparam logic [15:0] PIX1 = 16'd0;
`endif

    video_timing_checker #(
        .H_TOTAL(16'd110), .H_VAL(16'd100), .V_TOTAL(16'd8), .V_VAL(16'd5),
        .LOCK_FRAMES(4'd2), .BAR_W(16'd12)
    ) dut (
        .px_clk(px_clk), .rstn(rstn), .hsync(hsync), .vsync(vsync), .dval(dval),
        .px_data(px_data), .meas_h_total(meas_h_total), .meas_h_val(meas_h_val),
        .meas_v_total(meas_v_total), .meas_v_val(meas_v_val), .frame_cnt(frame_cnt),
        .locked(locked), .timing_err(timing_err), .err_cnt(err_cnt),
        .pix_err_cnt(pix_err_cnt)
    );

    always #5 px_clk = ~px_clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int          cyc     = 0;
    int          t_vs    = 0;

    always @(posedge px_clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [15:0] ht;
        logic [15:0] fc;
        logic [7:0]  ec;
        logic        lk;
        logic        te;
        logic [15:0] pix;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic [15:0] prev_fc = 16'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] bar_colour(input int k);
        int b;
        b = k / 12;
        if (b > 7) b = 7;
        case (b)
            0: return 24'hFF0000;
            1: return 24'h00FF00;
            2: return 24'h0000FF;
            3: return 24'hFFFFFF;
            4: return 24'hFFFF00;
            5: return 24'h00FFFF;
            6: return 24'hFF00FF;
            default: return 24'h123456;
        endcase
    endfunction

    // Expected result of the next frame close (all geometry except ht is nominal)
    task automatic push(input int ht, input int fc, input int ec, input logic lk,
                        input logic te, input logic [15:0] pix);
        exp_t e;
        e.ht = 16'(ht); e.fc = 16'(fc); e.ec = 8'(ec);
        e.lk = lk; e.te = te; e.pix = pix;
        exp_q.push_back(e);
    endtask

    // One frame: vsync with the first hsync, dval on lines 1..5, px 5..104
    task automatic frame(input int ht, input int nlines, input int force_line);
        for (int l = 0; l < nlines; l++) begin
            for (int c = 0; c < ht; c++) begin
                @(negedge px_clk);
                if (l == force_line && c == 101) chk("pix_before", 32'(pix_err_cnt), 32'd0);
                if (l == force_line && c == 102) chk("pix_after", 32'(pix_err_cnt), 32'(PIX1));
                hsync = (c < 4);
                vsync = (l == 0) && (c < 4);
                if (l == 0 && c == 0) t_vs = cyc;
                dval = (l >= 1) && (l <= 5) && (c >= 5) && (c < 105);
                if (!dval)
                    px_data = 24'd0;
                else if (l == force_line && c == 100)
                    px_data = 24'h000000;
                else
                    px_data = bar_colour(c - 5);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge px_clk);
            hsync = 1'b0; vsync = 1'b0; dval = 1'b0; px_data = 24'd0;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mht"}, 32'(meas_h_total), 32'd0);
        chk({tag, "_mhv"}, 32'(meas_h_val), 32'd0);
        chk({tag, "_mvt"}, 32'(meas_v_total), 32'd0);
        chk({tag, "_mvv"}, 32'(meas_v_val), 32'd0);
        chk({tag, "_fc"}, 32'(frame_cnt), 32'd0);
        chk({tag, "_lk"}, 32'(locked), 32'd0);
        chk({tag, "_te"}, 32'(timing_err), 32'd0);
        chk({tag, "_ec"}, 32'(err_cnt), 32'd0);
        chk({tag, "_pix"}, 32'(pix_err_cnt), 32'd0);
    endtask

    // Monitor: each frame_cnt change pops one expectation and compares
    always @(negedge px_clk) begin
        if (!rstn) begin
            prev_fc = 16'd0;
        end else if (frame_cnt != prev_fc) begin
            prev_fc = frame_cnt;
            if (exp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_frame: frame_cnt %0d, expected no frame close", frame_cnt);
            end else begin
                mon_e = exp_q.pop_front();
                chk("frame_cnt", 32'(frame_cnt), 32'(mon_e.fc));
                chk("meas_h_total", 32'(meas_h_total), 32'(mon_e.ht));
                chk("meas_h_val", 32'(meas_h_val), 32'd100);
                chk("meas_v_total", 32'(meas_v_total), 32'd8);
                chk("meas_v_val", 32'(meas_v_val), 32'd5);
                chk("err_cnt", 32'(err_cnt), 32'(mon_e.ec));
                chk("locked", 32'(locked), 32'(mon_e.lk));
                chk("timing_err", 32'(timing_err), 32'(mon_e.te));
                chk("pix_err_cnt", 32'(pix_err_cnt), 32'(mon_e.pix));
                chk("frame_latency", 32'(cyc - t_vs), 32'd2);
            end
        end else if (timing_err) begin
            n_tests++; n_fail++;
            $display("FAIL spurious_timing_err: timing_err 1 with no frame close, expected 0");
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        repeat (3) @(negedge px_clk);
        chk_zero("reset");
        rstn = 1'b1;

        // Acquire lock on nominal frames
        frame(110, 8, -1);
        push(110, 1, 0, 1'b0, 1'b0, 16'd0); frame(110, 8, -1);
        push(110, 2, 0, 1'b1, 1'b0, 16'd0); frame(110, 8, -1);
        push(110, 3, 0, 1'b1, 1'b0, 16'd0); frame(111, 8, -1);
        // Long-line frame drops lock, two good frames regain it
        push(111, 4, 1, 1'b0, 1'b1, 16'd0); frame(110, 8, -1);
        push(110, 5, 1, 1'b0, 1'b0, 16'd0); frame(110, 8, -1);
        push(110, 6, 1, 1'b1, 1'b0, 16'd0); frame(110, 8, 2);
        push(110, 7, 1, 1'b1, 1'b0, PIX1);  frame(110, 3, -1);

        // hsync stops: lock held until the 65535-cycle timeout, then lost
        idle(60000);
        chk("locked_pre_timeout", 32'(locked), 32'd1);
        idle(6000);
        chk("locked_timeout", 32'(locked), 32'd0);
        chk("to_mht", 32'(meas_h_total), 32'd110);
        chk("to_mvt", 32'(meas_v_total), 32'd8);
        chk("to_mvv", 32'(meas_v_val), 32'd5);
        chk("to_fc", 32'(frame_cnt), 32'd7);

        // First vsync after timeout only starts a frame
        frame(110, 8, -1);
        chk("resume_fc", 32'(frame_cnt), 32'd7);
        chk("resume_ec", 32'(err_cnt), 32'd1);
        chk("resume_lk", 32'(locked), 32'd0);
        chk("resume_mvt", 32'(meas_v_total), 32'd8);
        chk("resume_mvv", 32'(meas_v_val), 32'd5);
        push(110, 8, 1, 1'b0, 1'b0, PIX1);  frame(110, 8, -1);
        push(110, 9, 1, 1'b1, 1'b0, PIX1);  frame(110, 8, -1);
        push(110, 10, 1, 1'b1, 1'b0, PIX1); frame(110, 4, -1);

        // Reset mid-frame while locked
        @(negedge px_clk);
        #1 rstn = 1'b0;
        #1 chk_zero("midreset");
        idle(3);
        #1 rstn = 1'b1;
        frame(110, 8, -1);
        push(110, 1, 0, 1'b0, 1'b0, 16'd0); frame(110, 8, -1);
        push(110, 2, 0, 1'b1, 1'b0, 16'd0); frame(110, 8, -1);
        idle(10);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/video_timing_checker.md
# video_timing_checker

Sink-side companion to the on-chip video pattern generator: consumes a parallel video stream (hsync, vsync, dval, 24-bit pixel) on the pixel clock and measures line and frame geometry. It compares the geometry against expected parameters, runs a lock state machine and counts timing errors. It sits in the simulation library and on-board debug path, after the generator or after a MIPI receive chain, and gives a self-checking verdict per frame.

## Interface
- H_TOTAL, 16'd1252, expected px_clk cycles per line (hsync rise to hsync rise)
- H_VAL, 16'd1242, expected dval-high cycles per active line
- V_TOTAL, 16'd2707, expected hsync rises per frame (vsync rise to vsync rise)
- V_VAL, 16'd1920, expected lines per frame containing at least one dval cycle
- LOCK_FRAMES, 4'd2, consecutive matching frames required to assert locked
- BAR_W, 16'd90, colour-bar width in pixels (pattern check only)
- px_clk  in  1  pixel clock
- rstn  in  1  asynchronous active-low reset
- hsync  in  1  line sync, active high
- vsync  in  1  frame sync, active high
- dval  in  1  pixel valid, qualifies px_data in the same cycle
- px_data  in  24  pixel, RGB888
- meas_h_total / meas_h_val / meas_v_total / meas_v_val  out  16 each  last completed frame's measurements
- frame_cnt  out  16  completed frames, wraps 16'hFFFF -> 0
- locked  out  1  geometry stable and equal to parameters
- timing_err  out  1  one-cycle pulse when a completed frame mismatches
- err_cnt  out  8  mismatching frames, saturates at 8'hFF
- pix_err_cnt  out  16  pixel pattern mismatches, saturates at 16'hFFFF

## Operation
- All inputs are registered once (stage S1). Rise and fall edges are detected on S1 against its previous value.
- Line counter: cleared to 1 on an S1 hsync rise, otherwise increments, saturating at 16'hFFFF. On each rise the prior count goes to line_len.
- Active counter: counts S1 dval cycles and clears on an hsync rise. On a dval fall its value goes to act_len.
- Frame counters count hsync rises (v_tot) and lines with any dval (v_act). Both saturate at 16'hFFFF.
- On an S1 vsync rise, the frame ends:
  - meas_* are loaded from line_len, act_len, v_tot and v_act.
  - v_tot and v_act clear to 0.
  - frame_cnt increments.
  - The result is compared against the parameters.
- The first vsync rise after reset or timeout only starts a frame. It makes no comparison and does not increment frame_cnt.
- State machine, IDLE -> MEASURE -> LOCKED:
  - IDLE: waits for a vsync rise, then goes to MEASURE with match_cnt = 0.
  - MEASURE: each match increments match_cnt. When match_cnt reaches LOCK_FRAMES, go to LOCKED. A mismatch clears match_cnt.
  - LOCKED: a mismatch returns to MEASURE with match_cnt = 0.
  - Every mismatch, in any state, pulses timing_err and increments err_cnt.
- Timeout: if there is no hsync rise for 65535 cycles, go to IDLE from any state, deassert locked and keep meas_*.
- A simultaneous hsync rise and vsync rise closes the frame first. The line then counts into the new frame (v_tot = 1).
- Reset values: every output is 0, the state is IDLE and all counters are 0. Reset mid-frame discards partial counts.

## Timing
- The internal vsync rise is visible 1 cycle after the input rise.
- meas_*, frame_cnt, timing_err, err_cnt and locked update 2 cycles after the input vsync rise.
- locked is registered and equals (state == LOCKED).
- pix_err_cnt updates 2 cycles after the offending pixel.

## Configuration
- PATTERN_CHECK_EN defined: each dval run indexes pixels k = 0,1,…, and the bar index is min(k / BAR_W, 7).
  - Expected colours by bar index: ff0000, 00ff00, 0000ff, ffffff, ffff00, 00ffff, ff00ff, 123456.
  - A mismatching pixel increments pix_err_cnt. The pixel index resets when dval is low.
- PATTERN_CHECK_EN undefined: no pattern logic is built and pix_err_cnt is tied to 0.

## Test plan
- Default-geometry stream, 4 frames -> meas_h_total = 1252, meas_h_val = 1242, meas_v_total = 2707, meas_v_val = 1920. locked rises 2 cycles after the 3rd vsync rise, err_cnt = 0, frame_cnt = 3.
- While locked, one frame with H_TOTAL 1253 -> timing_err pulse, err_cnt = 1, locked drops. locked re-asserts after 2 good frames.
- Stop hsync for 65535 cycles -> state IDLE, locked = 0, meas_* unchanged. On resume, the first vsync rise makes no comparison.
- Assert rstn low mid-frame while locked -> all outputs 0 immediately. Lock is regained after the 1 + LOCK_FRAMES vsync rises.
- Pattern check with macro defined: correct colour bars -> pix_err_cnt = 0. Force pixel 95 of one line to 000000 -> pix_err_cnt = 1.
- Same forced pixel with macro undefined -> pix_err_cnt stays 0.
